// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: WIDTH-bit pipeline stage register with valid/ready handshake,
// a two-entry skid buffer (in_ready is a pure function of state flops) and a
// synchronous flush that squashes held entries and counts them.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   in_valid     upstream has data on in_data
//   in_ready     stage can accept (state flop decode, no path from out_ready)
//   in_data      upstream payload
//   out_valid    out_data holds a valid entry
//   out_ready    downstream accepts
//   out_data     payload to downstream (main register)
//   flush        synchronous squash of all held entries
//   occupancy    entries held: 0, 1 or 2
//   flush_drops  saturating count of entries discarded by flush
module pipe_stage_reg #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [7:0]       flush_drops
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned OCC_W   = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Encoding chosen so the state flops are the occupancy count directly.
  typedef enum logic [OCC_W-1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_FULL  = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]   drops_q, drops_d;

  logic               in_fire_c;
  logic               out_fire_c;
  logic [OCC_W-1:0]   drop_n_c;
  logic [CNT_W:0]     drop_sum_c;

  // Handshake outputs decoded straight from state flops.
  assign in_ready    = ~state_q[1];
  assign out_valid   = state_q[1] | state_q[0];
  assign occupancy   = state_q;
  assign out_data    = main_q;
  assign flush_drops = drops_q;

  assign in_fire_c  = in_valid & in_ready;
  assign out_fire_c = out_valid & out_ready;

  // Entries discarded by a flush: those held, less one delivered this cycle.
  assign drop_n_c   = state_q - OCC_W'(out_fire_c);
  assign drop_sum_c = {1'b0, drops_q} + (CNT_W+1)'(drop_n_c);

  // Next-state, data-path and counter logic.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    drops_d = drops_q;

    if (flush) begin
      state_d = S_EMPTY;
      drops_d = drop_sum_c[CNT_W] ? CNT_MAX : drop_sum_c[CNT_W-1:0];
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire_c) begin
            main_d  = in_data;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (in_fire_c && out_fire_c) begin
            main_d = in_data;
          end else if (in_fire_c) begin
            skid_d  = in_data;
            state_d = S_FULL;
          end else if (out_fire_c) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_fire_c) begin
            main_d  = skid_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // State, data and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
      drops_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      drops_q <= drops_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a queue scoreboard and an
// independent occupancy/flush-count model.
module tb_pipe_stage_reg;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] RV = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         flush;
  logic [1:0]   occupancy;
  logic [7:0]   flush_drops;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] sb_q[$];
  int           m_drops = 0;

  pipe_stage_reg #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .flush      (flush),
    .occupancy  (occupancy),
    .flush_drops(flush_drops)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check against the model, update model, take the edge.
  task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    int  sz;
    bit  m_in_ready, m_out_valid, ifire, ofire;
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #1;
    sz          = sb_q.size();
    m_in_ready  = (sz != 2);
    m_out_valid = (sz != 0);
    chk("occupancy", W'(occupancy), W'(sz));
    chk("in_ready", W'(in_ready), W'(m_in_ready));
    chk("out_valid", W'(out_valid), W'(m_out_valid));
    chk("flush_drops", W'(flush_drops), W'(m_drops));
    ifire = iv & m_in_ready;
    ofire = ordy & m_out_valid;
    if (ofire) chk("out_data", out_data, sb_q.pop_front());
    if (fl) begin
      m_drops = m_drops + sz - int'(ofire);
      if (m_drops > 255) m_drops = 255;
      sb_q.delete();
    end else if (ifire) begin
      sb_q.push_back(d);
    end
    @(posedge clk);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;

    // Reset held with toggling inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); out_ready = 1'($urandom); flush = 1'($urandom);
      in_data = $urandom;
      #1;
      chk("rst_out_valid", W'(out_valid), '0);
      chk("rst_in_ready", W'(in_ready), W'(1));
      chk("rst_occupancy", W'(occupancy), '0);
      chk("rst_out_data", out_data, RV);
      chk("rst_flush_drops", W'(flush_drops), '0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; reset = 1'b1;

    // Streaming 1..100 at full rate.
    for (int i = 1; i <= 100; i++) step(1'b1, W'(i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: C is held by the producer until space frees.
    step(1'b1, W'(32'hA), 1'b0, 1'b0);
    step(1'b1, W'(32'hB), 1'b0, 1'b0);
    step(1'b1, W'(32'hC), 1'b0, 1'b0);
    step(1'b1, W'(32'hC), 1'b0, 1'b0);
    step(1'b1, W'(32'hC), 1'b1, 1'b0);
    step(1'b1, W'(32'hC), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush while full, then flush with a delivery in the same cycle.
    step(1'b1, W'(32'h11), 1'b0, 1'b0);
    step(1'b1, W'(32'h22), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("drops_after_full_flush", W'(flush_drops), W'(2));
    step(1'b1, W'(32'h33), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush with an incoming entry while empty: discarded.
    step(1'b1, W'(32'h44), 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Saturation of the flush counter.
    for (int i = 0; i < 130; i++) begin
      step(1'b1, W'(i), 1'b0, 1'b0);
      step(1'b1, W'(i + 1000), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    chk("drops_saturated", W'(flush_drops), W'(255));

    // Asynchronous reset with two entries held, between edges.
    step(1'b1, W'(32'h55), 1'b0, 1'b0);
    step(1'b1, W'(32'h66), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_occupancy", W'(occupancy), '0);
    chk("arst_out_valid", W'(out_valid), '0);
    chk("arst_in_ready", W'(in_ready), W'(1));
    chk("arst_out_data", out_data, RV);
    chk("arst_flush_drops", W'(flush_drops), '0);
    @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    m_drops = 0;
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, W'(32'h77), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
